// File: rtl/mdu_arb_if.sv
// mdu_arb_if: bundles the two requester ports, the MDU-side issue/read bus,
// and the status outputs of the MDU issue arbiter.
//   slave  : arbiter side (takes requests and MDU status, drives grants and MDU issue)
//   master : environment side (drives requests and MDU status)
interface mdu_arb_if;
  logic        flush0;
  logic        r0_valid;
  logic [3:0]  r0_op;
  logic [31:0] r0_a, r0_b;
  logic        r0_ready, r0_rsp_valid;
  logic [31:0] r0_rsp_data;
  logic        r1_valid;
  logic [3:0]  r1_op;
  logic [31:0] r1_a, r1_b;
  logic        r1_ready, r1_rsp_valid;
  logic [31:0] r1_rsp_data;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a, mdu_b, mdu_rdata;
  logic        mdu_busy;
  logic        hilo_owner;
  logic        err;

  modport slave (
    input  flush0, r0_valid, r0_op, r0_a, r0_b, r1_valid, r1_op, r1_a, r1_b,
           mdu_rdata, mdu_busy,
    output r0_ready, r0_rsp_valid, r0_rsp_data, r1_ready, r1_rsp_valid, r1_rsp_data,
           mdu_op, mdu_a, mdu_b, hilo_owner, err
  );

  modport master (
    output flush0, r0_valid, r0_op, r0_a, r0_b, r1_valid, r1_op, r1_a, r1_b,
           mdu_rdata, mdu_busy,
    input  r0_ready, r0_rsp_valid, r0_rsp_data, r1_ready, r1_rsp_valid, r1_rsp_data,
           mdu_op, mdu_a, mdu_b, hilo_owner, err
  );
endinterface

// File: rtl/mdu_arbiter.sv
// mdu_arbiter: issue controller and two-port arbiter for the shared
// multiply/divide unit. Requester 0 is the E stage (squashable by flush0),
// requester 1 a secondary master. One op is granted per cycle; once a
// mult/div issues, nothing else is granted until the MDU drops busy.
// mfhi/mflo data is sampled in the grant cycle and returned one cycle later.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : requester ports r0_*/r1_*, flush0, MDU issue mdu_op/a/b,
//                 MDU status mdu_rdata/mdu_busy, hilo_owner, err
// Parameters: PRIO0 (1 = r0 fixed priority, 0 = round-robin), TIMEOUT.
// Optional feature macro MDU_TIMEOUT_EN: busy-phase watchdog driving sticky err.
module mdu_arbiter #(
  parameter bit PRIO0   = 1'b1,
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       reset,
  mdu_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BUSY = 2'd2} state_t;

  state_t           state_q;
  logic             last_q;       // requester granted most recently
  logic             owner_q;
  logic [1:0]       rsp_vld_q;
  logic [1:0][31:0] rsp_data_q;

  logic [1:0]  elig, gnt;
  logic        can_grant, pick1, sel, any_gnt;
  logic        op_md, op_rd, op_wr, op_ok, go_armed;
  logic [3:0]  sel_op;
  logic [31:0] sel_a, sel_b;

  assign elig = {bus.r1_valid, bus.r0_valid & ~bus.flush0};

  // Grants open in IDLE, or in the BUSY cycle where the MDU first reports
  // idle. A busy MDU seen while IDLE blocks grants as well.
  assign can_grant = ~reset & ~bus.mdu_busy & ((state_q == IDLE) || (state_q == BUSY));

  always_comb begin
    pick1 = elig[1] & (~elig[0] | (~PRIO0 & ~last_q));
    gnt   = 2'b00;
    if (can_grant) gnt = pick1 ? 2'b10 : {1'b0, elig[0]};
  end

  assign any_gnt  = |gnt;
  assign sel      = gnt[1];
  assign sel_op   = sel ? bus.r1_op : bus.r0_op;
  assign sel_a    = sel ? bus.r1_a  : bus.r0_a;
  assign sel_b    = sel ? bus.r1_b  : bus.r0_b;
  assign op_md    = sel_op inside {[4'd1:4'd4]};
  assign op_rd    = sel_op inside {[4'd5:4'd6]};
  assign op_wr    = sel_op inside {[4'd7:4'd8]};
  assign op_ok    = op_md | op_rd | op_wr;
  assign go_armed = any_gnt & op_md;

`ifdef MDU_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
`ifdef MDU_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      rsp_vld_q <= gnt & {2{op_rd}};
      if (any_gnt & op_rd) rsp_data_q[sel] <= bus.mdu_rdata;
      if (any_gnt) last_q <= sel;
      if (any_gnt & (op_md | op_wr)) owner_q <= sel;

      case (state_q)
        IDLE:    if (go_armed) state_q <= ARMED;
                 else if (bus.mdu_busy) state_q <= BUSY;
        ARMED:   state_q <= BUSY;   // MDU busy not yet visible this cycle
        BUSY:    if (!bus.mdu_busy) state_q <= go_armed ? ARMED : IDLE;
        default: state_q <= IDLE;
      endcase

`ifdef MDU_TIMEOUT_EN
      // Counts cycles spent in ARMED/BUSY; restarts on every new issue.
      if (state_q == IDLE || go_armed) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 8'd1;
        if (to_cnt_q == 8'(TIMEOUT - 1)) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end
      end
`endif
    end
  end

  assign bus.r0_ready     = gnt[0];
  assign bus.r1_ready     = gnt[1];
  assign bus.mdu_op       = (any_gnt & op_ok) ? sel_op : 4'd0;
  assign bus.mdu_a        = any_gnt ? sel_a : 32'd0;
  assign bus.mdu_b        = any_gnt ? sel_b : 32'd0;
  assign bus.r0_rsp_valid = rsp_vld_q[0];
  assign bus.r1_rsp_valid = rsp_vld_q[1];
  assign bus.r0_rsp_data  = rsp_data_q[0];
  assign bus.r1_rsp_data  = rsp_data_q[1];
  assign bus.hilo_owner   = owner_q;
`ifdef MDU_TIMEOUT_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter. dut uses fixed priority, dut_rr round-robin;
// dut_rr mirrors dut's requester inputs and sees an always-idle MDU.
// A small MDU stub drives busy/rdata for dut; read responses go through a
// per-port scoreboard queue.
module tb_mdu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_arb_if ifa();
  mdu_arb_if ifb();

  mdu_arbiter #(.PRIO0(1'b1), .TIMEOUT(16)) dut    (.clk(clk), .reset(reset), .bus(ifa.slave));
  mdu_arbiter #(.PRIO0(1'b0), .TIMEOUT(16)) dut_rr (.clk(clk), .reset(reset), .bus(ifb.slave));

  assign ifb.flush0    = ifa.flush0;
  assign ifb.r0_valid  = ifa.r0_valid;
  assign ifb.r0_op     = ifa.r0_op;
  assign ifb.r0_a      = ifa.r0_a;
  assign ifb.r0_b      = ifa.r0_b;
  assign ifb.r1_valid  = ifa.r1_valid;
  assign ifb.r1_op     = ifa.r1_op;
  assign ifb.r1_a      = ifa.r1_a;
  assign ifb.r1_b      = ifa.r1_b;
  assign ifb.mdu_busy  = 1'b0;
  assign ifb.mdu_rdata = 32'd0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // MDU stub: operands treated as unsigned (all stimulus is non-negative);
  // busy for 4 cycles starting the cycle after a mult/div issue.
  logic [31:0] hi, lo;
  int          busy_cnt;
  logic        force_busy = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0; lo <= 32'd0; busy_cnt <= 0;
    end else begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      case (ifa.mdu_op)
        4'd1, 4'd2: {hi, lo} <= {32'd0, ifa.mdu_a} * {32'd0, ifa.mdu_b};
        4'd3, 4'd4: if (ifa.mdu_b != 0) begin
                      lo <= ifa.mdu_a / ifa.mdu_b;
                      hi <= ifa.mdu_a % ifa.mdu_b;
                    end
        4'd7: hi <= ifa.mdu_a;
        4'd8: lo <= ifa.mdu_a;
        default: ;
      endcase
      if (ifa.mdu_op inside {[4'd1:4'd4]}) busy_cnt <= 4;
    end
  end
  assign ifa.mdu_busy  = (busy_cnt != 0) || force_busy;
  assign ifa.mdu_rdata = (ifa.mdu_op == 4'd6) ? lo : hi;

  // Scoreboard: expected read data pushed when the grant is checked.
  logic [31:0] q0[$], q1[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (ifa.r0_rsp_valid) begin
        if (q0.size() == 0) chk("r0_rsp_unexpected", 32'd1, 32'd0);
        else chk("r0_rsp_data", ifa.r0_rsp_data, q0.pop_front());
      end
      if (ifa.r1_rsp_valid) begin
        if (q1.size() == 0) chk("r1_rsp_unexpected", 32'd1, 32'd0);
        else chk("r1_rsp_data", ifa.r1_rsp_data, q1.pop_front());
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic neg();  @(negedge clk);     endtask
  task automatic req0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ifa.r0_valid = v; ifa.r0_op = op; ifa.r0_a = a; ifa.r0_b = b;
  endtask
  task automatic req1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ifa.r1_valid = v; ifa.r1_op = op; ifa.r1_a = a; ifa.r1_b = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ifa.flush0 = 1'b0;
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    req1(1'b0, 4'd0, 32'd0, 32'd0);
    reset = 1'b1;
    tick(); tick();

    // reset values
    neg();
    chk("rst_r0_ready", ifa.r0_ready, 0);
    chk("rst_r1_ready", ifa.r1_ready, 0);
    chk("rst_r0_rsp_valid", ifa.r0_rsp_valid, 0);
    chk("rst_r1_rsp_valid", ifa.r1_rsp_valid, 0);
    chk("rst_rsp_data", ifa.r0_rsp_data | ifa.r1_rsp_data, 0);
    chk("rst_mdu_op", ifa.mdu_op, 0);
    chk("rst_owner", ifa.hilo_owner, 0);
    chk("rst_err", ifa.err, 0);
    tick();
    reset = 1'b0;

    // both hold mtlo: fixed priority starves r1, round-robin alternates
    req0(1'b1, 4'd8, 32'd1, 32'd0);
    req1(1'b1, 4'd8, 32'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("prio_r0_ready", ifa.r0_ready, 1);
      chk("prio_r1_ready", ifa.r1_ready, 0);
      chk("rr_r0_ready", ifb.r0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_r1_ready", ifb.r1_ready, (i % 2 == 1) ? 1 : 0);
      chk("rr_mdu_a", ifb.mdu_a, (i % 2 == 0) ? 1 : 2);
      tick();
    end
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    req1(1'b0, 4'd0, 32'd0, 32'd0);
    tick(); tick(); tick();

    // r0 mult 3*5 blocks a held r1 mfhi until busy falls
    req0(1'b1, 4'd1, 32'd3, 32'd5);
    req1(1'b1, 4'd5, 32'd0, 32'd0);
    neg();
    chk("mult_r0_ready", ifa.r0_ready, 1);
    chk("mult_r1_ready", ifa.r1_ready, 0);
    chk("mult_mdu_op", ifa.mdu_op, 1);
    chk("mult_mdu_a", ifa.mdu_a, 3);
    chk("mult_mdu_b", ifa.mdu_b, 5);
    tick();
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      neg();
      chk("blocked_r1_ready", ifa.r1_ready, 0);
      chk("blocked_mdu_op", ifa.mdu_op, 0);
      tick();
    end
    neg();
    chk("mfhi_r1_ready", ifa.r1_ready, 1);
    chk("mfhi_mdu_op", ifa.mdu_op, 5);
    q1.push_back(32'd0);
    tick();
    req1(1'b0, 4'd0, 32'd0, 32'd0);
    neg();
    chk("mult_owner", ifa.hilo_owner, 0);
    tick();

    // invalid op accepted without issue, next op granted right after
    req0(1'b1, 4'hC, 32'h11, 32'h22);
    neg();
    chk("inv_r0_ready", ifa.r0_ready, 1);
    chk("inv_mdu_op", ifa.mdu_op, 0);
    tick();
    req0(1'b1, 4'd8, 32'h55, 32'd0);
    neg();
    chk("after_inv_ready", ifa.r0_ready, 1);
    chk("after_inv_mdu_op", ifa.mdu_op, 8);
    chk("after_inv_mdu_a", ifa.mdu_a, 32'h55);
    tick();
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    req1(1'b1, 4'd7, 32'hAAAA, 32'd0);
    neg();
    chk("mthi_r1_ready", ifa.r1_ready, 1);
    chk("mthi_mdu_op", ifa.mdu_op, 7);
    tick();
    req1(1'b0, 4'd0, 32'd0, 32'd0);
    req0(1'b1, 4'd6, 32'd0, 32'd0);
    neg();
    chk("mthi_owner", ifa.hilo_owner, 1);
    chk("mflo_r0_ready", ifa.r0_ready, 1);
    q0.push_back(32'h55);
    tick();
    req0(1'b1, 4'd5, 32'd0, 32'd0);
    neg();
    chk("mfhi_r0_ready", ifa.r0_ready, 1);
    q0.push_back(32'hAAAA);
    tick();
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    neg(); tick();
    neg();
    chk("rsp_hold_data", ifa.r0_rsp_data, 32'hAAAA);
    chk("rsp_hold_valid", ifa.r0_rsp_valid, 0);
    tick();

    // flush0 squashes r0 div; r1 mflo wins; r0 granted once flush drops
    ifa.flush0 = 1'b1;
    req0(1'b1, 4'd3, 32'd100, 32'd7);
    req1(1'b1, 4'd6, 32'd0, 32'd0);
    neg();
    chk("flush_r0_ready", ifa.r0_ready, 0);
    chk("flush_r1_ready", ifa.r1_ready, 1);
    chk("flush_mdu_op", ifa.mdu_op, 6);
    q1.push_back(32'h55);
    tick();
    ifa.flush0 = 1'b0;
    req1(1'b0, 4'd0, 32'd0, 32'd0);
    neg();
    chk("div_r0_ready", ifa.r0_ready, 1);
    chk("div_mdu_op", ifa.mdu_op, 3);
    chk("div_mdu_a", ifa.mdu_a, 100);
    tick();
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    req1(1'b1, 4'd7, 32'h77, 32'd0);
    ifa.flush0 = 1'b1;
    neg();
    chk("armed_r1_ready", ifa.r1_ready, 0);
    tick();
    ifa.flush0 = 1'b0;
    n = 0;
    while (n < 20) begin
      neg();
      if (ifa.r1_ready) break;
      tick();
      n++;
    end
    chk("div_busy_wait", n, 3);
    tick();
    req1(1'b0, 4'd0, 32'd0, 32'd0);
    req0(1'b1, 4'd6, 32'd0, 32'd0);
    neg();
    chk("owner_after_mthi", ifa.hilo_owner, 1);
    chk("div_mflo_ready", ifa.r0_ready, 1);
    q0.push_back(32'd14);
    tick();
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    neg(); tick();

    // reset two cycles after an r1 divu grant
    req1(1'b1, 4'd4, 32'd9, 32'd2);
    neg();
    chk("divu_r1_ready", ifa.r1_ready, 1);
    chk("divu_mdu_op", ifa.mdu_op, 4);
    tick();
    req1(1'b0, 4'd0, 32'd0, 32'd0);
    neg();
    chk("divu_owner", ifa.hilo_owner, 1);
    tick();
    reset = 1'b1;
    tick();
    neg();
    chk("mid_rst_owner", ifa.hilo_owner, 0);
    chk("mid_rst_r0_data", ifa.r0_rsp_data, 0);
    chk("mid_rst_r1_data", ifa.r1_rsp_data, 0);
    chk("mid_rst_mdu_op", ifa.mdu_op, 0);
    chk("mid_rst_rsp_valid", ifa.r0_rsp_valid | ifa.r1_rsp_valid, 0);
    tick();
    reset = 1'b0;
    req0(1'b1, 4'd7, 32'h99, 32'd0);
    neg();
    chk("post_rst_ready", ifa.r0_ready, 1);
    chk("post_rst_mdu_op", ifa.mdu_op, 7);
    tick();

    // spurious busy in IDLE: no grant that cycle
    force_busy = 1'b1;
    req0(1'b1, 4'd8, 32'd5, 32'd0);
    neg();
    chk("spurious_ready", ifa.r0_ready, 0);
    tick();
    force_busy = 1'b0;
    neg();
    chk("spurious_release_ready", ifa.r0_ready, 1);
    tick();
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    tick();

`ifdef MDU_TIMEOUT_EN
    // watchdog: busy stuck after a mult
    req0(1'b1, 4'd1, 32'd1, 32'd1);
    neg();
    chk("to_mult_ready", ifa.r0_ready, 1);
    tick();
    req0(1'b0, 4'd0, 32'd0, 32'd0);
    force_busy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      neg();
      chk("to_err_low", ifa.err, 0);
      tick();
    end
    neg();
    chk("to_err_set", ifa.err, 1);
    tick();
    force_busy = 1'b0;
    req1(1'b1, 4'd7, 32'h3, 32'd0);
    neg();
    chk("to_idle_grant", ifa.r1_ready, 1);
    tick();
    req1(1'b0, 4'd0, 32'd0, 32'd0);
    tick(); tick();
    neg();
    chk("to_err_sticky", ifa.err, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    neg();
    chk("to_err_cleared", ifa.err, 0);
    tick();
`endif

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
